// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge: single AHB slave turning each transfer into one APB SETUP/ACCESS sequence with one-hot PSEL decode.
// Define APB_TIMEOUT_EN to turn an ACCESS phase left unanswered for TIMEOUT_CYCLES into an ERROR response.
module ahb_apb_bridge #(
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_W         = 32,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_W-1:0]     HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [31:0]           HRDATA,
    output logic [NUM_SLAVES-1:0] PSEL,
    output logic                  PENABLE,
    output logic [ADDR_W-1:0]     PADDR,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);
    typedef enum logic [2:0] {IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2} state_t;
    state_t                state, state_d;
    logic [3:0]            idx, idx_d, hidx;
    logic                  accept, dec_err, timeout, pwrite_d, unused_ok;
    logic [NUM_SLAVES-1:0] psel_d;
    logic [ADDR_W-1:0]     paddr_d;
    logic [31:0]           pwdata_d, hrdata_d;

    assign hidx      = HADDR[SEL_LSB+3:SEL_LSB];
    assign accept    = HSEL && HREADY && HTRANS[1] && (state == IDLE || state == ERR2);
    assign dec_err   = int'(hidx) >= NUM_SLAVES;
    assign unused_ok = ^{HTRANS[0], TIMEOUT_CYCLES};

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    // fires on the last permitted PREADY-low cycle, so ACCESS lasts exactly TIMEOUT_CYCLES
    assign timeout = state == ACCESS && !PREADY && wait_cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn)
            wait_cnt <= '0;
        else
            wait_cnt <= state != ACCESS ? '0 : wait_cnt + CW'(!PREADY);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state;
        case (state)
            IDLE, ERR2: state_d = !accept ? IDLE : dec_err ? ERR1 : HWRITE ? LATCH : SETUP;
            LATCH:      state_d = SETUP;
            SETUP:      state_d = ACCESS;
            ACCESS:     state_d = timeout || (PREADY && PSLVERR) ? ERR1 : PREADY ? IDLE : ACCESS;
            ERR1:       state_d = ERR2;
            default:    state_d = IDLE;
        endcase
        idx_d    = accept ? hidx : idx;
        paddr_d  = accept ? HADDR : PADDR;
        pwrite_d = accept ? HWRITE : PWRITE;
        pwdata_d = state == LATCH ? HWDATA : PWDATA;
        hrdata_d = state == ACCESS && PREADY && !PSLVERR && !PWRITE ? PRDATA : HRDATA;
        for (int i = 0; i < NUM_SLAVES; i++)
            psel_d[i] = (state_d == SETUP || state_d == ACCESS) && idx_d == 4'(i);
    end

    // outputs are registered from the next state so they line up with it
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            state     <= IDLE;
            idx       <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= 2'b00;
            HRDATA    <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            HREADYOUT <= state_d == IDLE || state_d == ERR2;
            HRESP     <= state_d == ERR1 || state_d == ERR2 ? 2'b01 : 2'b00;
            HRDATA    <= hrdata_d;
            PSEL      <= psel_d;
            PENABLE   <= state_d == ACCESS;
            PADDR     <= paddr_d;
            PWRITE    <= pwrite_d;
            PWDATA    <= pwdata_d;
        end
endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb_ahb_apb_bridge: directed-vector bench for ahb_apb_bridge with hand-computed expectations.
module tb_ahb_apb_bridge;
    logic        HCLK = 1'b0, HRESETn = 1'b0;
    logic        HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1;
    logic [31:0] HADDR = '0, HWDATA = '0, PRDATA = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic        PREADY = 1'b1, PSLVERR = 1'b0;
    logic        HREADYOUT, PENABLE, PWRITE;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA, PADDR, PWDATA;
    logic [3:0]  PSEL;
    int          n_cmp = 0, n_err = 0;

    ahb_apb_bridge dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRESP(HRESP), .HRDATA(HRDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr(input logic [31:0] a, input logic w);
        HSEL = 1'b1;
        HTRANS = 2'b10;
        HADDR = a;
        HWRITE = w;
        cyc();
        HSEL = 1'b0;
        HTRANS = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w, pe;
        cyc();
        cyc();
        chk("rst_hreadyout", HREADYOUT, 1);
        chk("rst_hresp", HRESP, 0);
        chk("rst_hrdata", HRDATA, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_pwdata", PWDATA, 0);
        HRESETn = 1'b1;
        cyc();

        // read slave 1, zero wait states
        addr(32'h0000_1004, 1'b0);
        chk("rd_setup_psel", PSEL, 4'b0010);
        chk("rd_setup_penable", PENABLE, 0);
        chk("rd_setup_hready", HREADYOUT, 0);
        chk("rd_setup_paddr", PADDR, 32'h0000_1004);
        PREADY = 1'b1;
        PRDATA = 32'hDEADBEEF;
        cyc();
        chk("rd_acc_penable", PENABLE, 1);
        chk("rd_acc_psel", PSEL, 4'b0010);
        chk("rd_acc_hready", HREADYOUT, 0);
        cyc();
        chk("rd_done_hready", HREADYOUT, 1);
        chk("rd_done_hrdata", HRDATA, 32'hDEADBEEF);
        chk("rd_done_hresp", HRESP, 0);
        chk("rd_done_psel", PSEL, 0);
        chk("rd_done_penable", PENABLE, 0);

        // write slave 2 with three PREADY-low ACCESS cycles
        addr(32'h0000_2008, 1'b1);
        HWDATA = 32'h12345678;
        PREADY = 1'b0;
        w = 0;
        pe = 0;
        for (int c = 0; c < 20 && !HREADYOUT; c++) begin
            w++;
            pe += int'(PENABLE);
            if (w == 1) chk("wr_latch_psel", PSEL, 0);
            if (w == 2) HWDATA = 32'hBADBAD00;
            if (PENABLE) begin
                chk("wr_psel", PSEL, 4'b0100);
                chk("wr_pwrite", PWRITE, 1);
                chk("wr_pwdata", PWDATA, 32'h12345678);
                chk("wr_paddr", PADDR, 32'h0000_2008);
            end
            PREADY = pe == 4;
            cyc();
        end
        chk("wr_waits", w, 6);
        chk("wr_penable_cycles", pe, 4);
        chk("wr_done_hresp", HRESP, 0);
        chk("wr_hrdata_kept", HRDATA, 32'hDEADBEEF);
        PREADY = 1'b1;

        // BUSY and unselected transfers are ignored
        HSEL = 1'b1;
        HTRANS = 2'b01;
        HADDR = 32'h0000_1000;
        cyc();
        chk("busy_hready", HREADYOUT, 1);
        chk("busy_psel", PSEL, 0);
        HSEL = 1'b0;
        HTRANS = 2'b10;
        cyc();
        chk("unsel_hready", HREADYOUT, 1);
        chk("unsel_psel", PSEL, 0);
        HSEL = 1'b1;
        HREADY = 1'b0;
        cyc();
        chk("nohready_psel", PSEL, 0);
        HSEL = 1'b0;
        HTRANS = 2'b00;
        HREADY = 1'b1;

        // read with slave error
        addr(32'h0000_0000, 1'b0);
        PREADY = 1'b1;
        PSLVERR = 1'b1;
        PRDATA = 32'h55555555;
        cyc();
        chk("slverr_penable", PENABLE, 1);
        cyc();
        chk("slverr_err1_hresp", HRESP, 1);
        chk("slverr_err1_hready", HREADYOUT, 0);
        chk("slverr_err1_psel", PSEL, 0);
        PSLVERR = 1'b0;
        cyc();
        chk("slverr_err2_hresp", HRESP, 1);
        chk("slverr_err2_hready", HREADYOUT, 1);
        cyc();
        chk("slverr_ok_hresp", HRESP, 0);
        chk("slverr_hrdata_kept", HRDATA, 32'hDEADBEEF);

        // decode error: slot 5 with four slaves
        addr(32'h0000_5000, 1'b0);
        chk("dec_err1_hresp", HRESP, 1);
        chk("dec_err1_hready", HREADYOUT, 0);
        chk("dec_err1_psel", PSEL, 0);
        cyc();
        chk("dec_err2_hresp", HRESP, 1);
        chk("dec_err2_hready", HREADYOUT, 1);
        chk("dec_err2_psel", PSEL, 0);
        cyc();
        chk("dec_ok_hresp", HRESP, 0);

        // read slave 0, then write slave 3 presented in the completion cycle
        addr(32'h0000_0010, 1'b0);
        PRDATA = 32'hCAFEF00D;
        cyc();
        cyc();
        chk("b2b_rd_hready", HREADYOUT, 1);
        chk("b2b_rd_hrdata", HRDATA, 32'hCAFEF00D);
        addr(32'h0000_3000, 1'b1);
        HWDATA = 32'hA5A5A5A5;
        chk("b2b_latch_hready", HREADYOUT, 0);
        chk("b2b_latch_penable", PENABLE, 0);
        cyc();
        chk("b2b_setup_psel", PSEL, 4'b1000);
        chk("b2b_setup_penable", PENABLE, 0);
        chk("b2b_setup_paddr", PADDR, 32'h0000_3000);
        chk("b2b_setup_pwrite", PWRITE, 1);
        cyc();
        chk("b2b_acc_penable", PENABLE, 1);
        chk("b2b_acc_pwdata", PWDATA, 32'hA5A5A5A5);
        cyc();
        chk("b2b_done_hready", HREADYOUT, 1);
        chk("b2b_done_psel", PSEL, 0);
        cyc();
        chk("b2b_no_dup_psel", PSEL, 0);
        chk("b2b_no_dup_hready", HREADYOUT, 1);

        // asynchronous reset during ACCESS
        addr(32'h0000_1000, 1'b0);
        PREADY = 1'b0;
        cyc();
        chk("rstmid_penable_pre", PENABLE, 1);
        #2 HRESETn = 1'b0;
        #1;
        chk("rstmid_psel", PSEL, 0);
        chk("rstmid_penable", PENABLE, 0);
        chk("rstmid_hready", HREADYOUT, 1);
        cyc();
        HRESETn = 1'b1;
        PREADY = 1'b1;
        cyc();
        chk("rstmid_idle_psel", PSEL, 0);
        chk("rstmid_idle_hresp", HRESP, 0);

`ifdef APB_TIMEOUT_EN
        // PREADY stuck low: ERROR after exactly 16 ACCESS cycles
        addr(32'h0000_1000, 1'b0);
        PREADY = 1'b0;
        pe = 0;
        cyc();
        for (int c = 0; c < 40 && PENABLE; c++) begin
            pe++;
            cyc();
        end
        chk("to_access_cycles", pe, 16);
        chk("to_err1_hresp", HRESP, 1);
        chk("to_err1_hready", HREADYOUT, 0);
        chk("to_err1_psel", PSEL, 0);
        PREADY = 1'b1;
        PRDATA = 32'h77777777;
        cyc();
        chk("to_err2_hready", HREADYOUT, 1);
        cyc();
        chk("to_ok_hresp", HRESP, 0);
        chk("to_hrdata_kept", HRDATA, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ahb_apb_bridge.md
Name: ahb_apb_bridge

Overview:
AHB-to-APB bridge and APB sequencer. Acts as a single AHB slave, converts each accepted AHB transfer into one APB SETUP/ACCESS sequence, and decodes the address to a one-hot PSEL for NUM_SLAVES peripherals. It sits behind the AHB arbiter/decoder and owns all APB handshake timing, wait-state insertion and error mapping back to HRESP.

Parameters:
NUM_SLAVES, 4, number of APB slaves; legal values 1..16.
ADDR_W, 32, HADDR/PADDR width.
SEL_LSB, 12, LSB of the 4-bit slave-index field HADDR[SEL_LSB+3:SEL_LSB], giving 4 KB slots.
TIMEOUT_CYCLES, 16, PREADY wait limit; used only with APB_TIMEOUT_EN.

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset; one clock, reset is asynchronous and active-low
HSEL  in  1  bridge selected by the AHB decoder
HADDR  in  ADDR_W  AHB address
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWRITE  in  1  1 = write
HWDATA  in  32  write data, valid in the data phase
HREADY  in  1  bus-level ready
HREADYOUT  out  1  bridge ready
HRESP  out  2  00 OKAY, 01 ERROR
HRDATA  out  32  read data
PSEL  out  NUM_SLAVES  one-hot APB select
PENABLE  out  1  APB access phase
PADDR  out  ADDR_W  APB address
PWRITE  out  1  APB direction
PWDATA  out  32  APB write data
PRDATA  in  32  APB read data, shared mux input
PREADY  in  1  APB ready of the selected slave
PSLVERR  in  1  APB error of the selected slave

Behaviour:
- Reset values (async, while HRESETn=0): HREADYOUT=1, HRESP=00, HRDATA=0, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, FSM=IDLE. All outputs are registered.
- FSM states: IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2.
- Accept: HSEL & HREADY & HTRANS[1] while the state is IDLE or ERR2. On accept, latch HADDR, HWRITE and idx=HADDR[SEL_LSB+3:SEL_LSB].
- BUSY, IDLE or unselected transfers: no state change. HREADYOUT stays 1 and HRESP stays 00.
- Decode error (idx >= NUM_SLAVES): go to ERR1. No PSEL is asserted and no LATCH state is entered.
- Write accepted: go to LATCH (HREADYOUT=0) and capture HWDATA into PWDATA, then go to SETUP.
- Read accepted: go directly to SETUP.
- SETUP (1 cycle): PSEL[idx]=1, PENABLE=0, PADDR and PWRITE valid, HREADYOUT=0. Next state is ACCESS.
- ACCESS: PENABLE=1. PSEL, PADDR, PWRITE and PWDATA are held stable while PREADY=0.
- PREADY=1 & PSLVERR=0: PSEL=0 and PENABLE=0 next cycle; state returns to IDLE with HREADYOUT=1 and HRESP=00. A read also loads HRDATA<=PRDATA.
- PREADY=1 & PSLVERR=1: go to ERR1. HRDATA is not updated.
- ERR1: HREADYOUT=0, HRESP=01. ERR2: HREADYOUT=1, HRESP=01. From ERR2, go to IDLE, or to LATCH/SETUP if a new transfer is accepted.
- Latency with zero APB waits: read = 2 AHB wait states (SETUP, ACCESS); write = 3 (LATCH, SETUP, ACCESS). Each PREADY-low cycle adds 1.
- Back-to-back transfers: a transfer accepted in the completion (IDLE) cycle enters SETUP/LATCH next cycle. PSEL may stay high across the boundary, but PENABLE must drop for at least one cycle.
- HRDATA holds its last successful read value; writes and errors do not change it.
- PSLVERR and PRDATA are ignored unless ACCESS & PREADY.
- Reset mid-transfer: the APB cycle is aborted immediately (PSEL/PENABLE=0) with no completion response.

Optional Feature:
APB_TIMEOUT_EN: when defined, a wait counter (clog2(TIMEOUT_CYCLES+1) bits) clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0. When it reaches TIMEOUT_CYCLES, the bridge drops PSEL/PENABLE and goes to ERR1; a late PREADY is ignored. When undefined, there is no counter, and the bridge waits indefinitely for PREADY.

Test Plan:
- Read HADDR=0x0000_1004, PREADY=1, PRDATA=0xDEADBEEF -> PSEL=0010 next cycle with PENABLE=0, PENABLE=1 the cycle after; HREADYOUT=1 with HRDATA=0xDEADBEEF and HRESP=00 on the 3rd cycle after the address phase.
- Write HADDR=0x0000_2008, HWDATA=0x12345678, PREADY low for 3 ACCESS cycles -> PSEL=0100, PWRITE=1 and PWDATA=0x12345678 stable throughout, PENABLE high 4 cycles, 6 AHB wait states.
- Read with PSLVERR=1 at PREADY=1 -> HRESP=01 for 2 cycles (HREADYOUT 0 then 1), then OKAY; HRDATA keeps its previous value.
- HADDR=0x0000_5000 (idx 5 >= 4) -> PSEL stays 0; two-cycle ERROR response starts the cycle after the address phase.
- Read to slave 0 with a NONSEQ write to slave 3 presented in the completion cycle -> LATCH, SETUP with PSEL=1000 and PENABLE=0, then ACCESS; no lost or duplicated transfer.
- HRESETn low during ACCESS -> PSEL=0, PENABLE=0, HREADYOUT=1 without waiting for HCLK. With APB_TIMEOUT_EN and PREADY stuck 0 -> ERR1 after exactly 16 ACCESS cycles.
